// File: rtl/sram_line_master.sv
// Moves one cache line over the SRAM controller stb/nak port, critical word first.
// Ports: clk/rst, req_* line request, rd_* read words, done/err, wb_* slave side.
module sram_line_master #(
  parameter int LINE_WORDS = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [31:0]                    req_addr,
  input  logic [LINE_WORDS*32-1:0]       req_wdata,
  output logic                           rd_valid,
  output logic [$clog2(LINE_WORDS)-1:0]  rd_idx,
  output logic [31:0]                    rd_data,
  output logic                           done,
  output logic                           err,
  output logic                           wb_stb,
  output logic [31:0]                    wb_addr,
  output logic [3:0]                     wb_we,
  output logic [31:0]                    wb_din,
  input  logic [47:0]                    wb_dout,
  input  logic                           wb_nak
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              write_q;
  logic [29-IW:0]    base;
  logic [IW-1:0]     start;
  logic [31:0]       line [LINE_WORDS];
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     comp_cnt;
  logic [7:0]        tmo;
  logic              nak_q;

  logic              accept;
  logic              complete;
  logic [IW-1:0]     req_start;
  logic [IW-1:0]     next_idx;
  logic [IW-1:0]     comp_idx;
  logic [31:0]       req_words [LINE_WORDS];
  logic              unused;

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_words
    assign req_words[g] = req_wdata[32*g +: 32];
  end

  // nak rising edge: slave took the word; falling edge: result cycle
  assign accept    = wb_nak & ~nak_q;
  assign complete  = ~wb_nak & nak_q;
  assign req_start = req_addr[IW+1:2];
  // IW-bit sums wrap inside the line by construction
  assign next_idx  = start + issue_cnt[IW-1:0] + IW'(1);
  assign comp_idx  = start + comp_cnt[IW-1:0];
  assign unused    = ^{wb_dout[47:32], req_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      base      <= '0;
      start     <= '0;
      issue_cnt <= '0;
      comp_cnt  <= '0;
      tmo       <= '0;
      nak_q     <= 1'b0;
      req_ready <= 1'b1;
      rd_valid  <= 1'b0;
      rd_idx    <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_stb    <= 1'b0;
      wb_addr   <= '0;
      wb_we     <= '0;
      wb_din    <= '0;
      for (int i = 0; i < LINE_WORDS; i++) line[i] <= '0;
    end else begin
      nak_q    <= wb_nak;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= BUSY;
            req_ready <= 1'b0;
            write_q   <= req_write;
            base      <= req_addr[31:IW+2];
            start     <= req_start;
            issue_cnt <= '0;
            comp_cnt  <= '0;
            tmo       <= '0;
            for (int i = 0; i < LINE_WORDS; i++) line[i] <= req_words[i];
            wb_stb    <= 1'b1;
            wb_addr   <= {req_addr[31:IW+2], req_start, 2'b00};
            wb_we     <= req_write ? 4'hF : 4'h0;
            wb_din    <= req_write ? req_words[req_start] : 32'h0;
          end
        end
        BUSY: begin
          if (accept) begin
            tmo <= '0;
            if (issue_cnt < LAST) begin
              issue_cnt <= issue_cnt + CW'(1);
              wb_addr   <= {base, next_idx, 2'b00};
              if (write_q) wb_din <= line[next_idx];
            end else begin
              wb_stb <= 1'b0;
            end
          end else if (complete) begin
            tmo      <= '0;
            comp_cnt <= comp_cnt + CW'(1);
            if (!write_q) begin
              rd_valid <= 1'b1;
              rd_idx   <= comp_idx;
              rd_data  <= wb_dout[31:0];
            end
            if (comp_cnt == LAST) begin
              state     <= IDLE;
              done      <= 1'b1;
              req_ready <= 1'b1;
              wb_stb    <= 1'b0;
            end
          end else if (tmo == TMO_LAST) begin
            // abort: drop the strobe and report; partial data is discarded
            state     <= IDLE;
            done      <= 1'b1;
            err       <= 1'b1;
            req_ready <= 1'b1;
            wb_stb    <= 1'b0;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_master.sv
// Directed bench for sram_line_master with a behavioural stb/nak slave.
// Checks word order, data, timing, writeback, timeout, reset and back-to-back.
module tb_sram_line_master;
  localparam int LW = 8;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [LW*32-1:0]  req_wdata;
  logic              rd_valid;
  logic [2:0]        rd_idx;
  logic [31:0]       rd_data;
  logic              done;
  logic              err;
  logic              wb_stb;
  logic [31:0]       wb_addr;
  logic [3:0]        wb_we;
  logic [31:0]       wb_din;
  logic [47:0]       wb_dout;
  logic              wb_nak;

  always #5 clk = ~clk;

  sram_line_master #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
    .done(done), .err(err),
    .wb_stb(wb_stb), .wb_addr(wb_addr), .wb_we(wb_we), .wb_din(wb_din),
    .wb_dout(wb_dout), .wb_nak(wb_nak)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave: sample when idle/result, nak high 2 cycles, then result cycle
  int          ph;
  logic        mute = 1'b0;
  logic [31:0] s_addr;
  logic [31:0] log_addr[$];
  logic [3:0]  log_we[$];
  logic [31:0] log_din[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph      <= 0;
      wb_nak  <= 1'b0;
      wb_dout <= '0;
      s_addr  <= '0;
    end else begin
      case (ph)
        0: begin
          if (wb_stb && !mute) begin
            ph     <= 1;
            wb_nak <= 1'b1;
            s_addr <= wb_addr;
            log_addr.push_back(wb_addr);
            log_we.push_back(wb_we);
            log_din.push_back(wb_din);
          end else begin
            wb_nak <= 1'b0;
          end
        end
        1: ph <= 2;
        default: begin
          ph      <= 0;
          wb_nak  <= 1'b0;
          wb_dout <= {16'hBEEF, 32'h000000A0 + {29'd0, s_addr[4:2]}};
        end
      endcase
    end
  end

  logic [2:0]  rq_idx[$];
  logic [31:0] rq_data[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;
  int          err_lone = 0;

  always @(negedge clk) begin
    if (rd_valid) begin
      rq_idx.push_back(rd_idx);
      rq_data.push_back(rd_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
    if (err && !done) err_lone++;
  end

  int n_run  = 0;
  int n_fail = 0;
  int base   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rq_idx.delete();
    rq_data.delete();
    log_addr.delete();
    log_we.delete();
    log_din.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic wr, input logic [31:0] a,
                      input logic [LW*32-1:0] wd);
    step();
    check("rdy_c0", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    base      = cyc;
    step();
    req_valid = 1'b0;
    check("stb_c1", 64'(wb_stb), 64'd1);
    check("rdy_c1", 64'(req_ready), 64'd0);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_fill(input int s, input int off, input string tag);
    for (int k = 0; k < LW; k++) begin
      int idx;
      idx = (s + k) % LW;
      if (off + k < rq_idx.size()) begin
        check({tag, "_idx"}, 64'(rq_idx[off+k]), 64'(idx));
        check({tag, "_data"}, 64'(rq_data[off+k]), 64'(32'hA0 + idx));
      end
    end
  endtask

  task automatic check_addrs(input logic [31:0] lbase, input int s,
                             input string tag);
    check({tag, "_nacc"}, 64'(log_addr.size()), 64'(LW));
    for (int k = 0; k < LW; k++) begin
      if (k < log_addr.size())
        check({tag, "_addr"}, 64'(log_addr[k]),
              64'(lbase + 32'(4 * ((s + k) % LW))));
    end
  endtask

  initial begin
    logic [LW*32-1:0] wd;
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [LW*32-1:0] wd;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    step();
    step();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_stb", 64'(wb_stb), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdv", 64'(rd_valid), 64'd0);
    check("rst_we", 64'(wb_we), 64'd0);
    check("rst_addr", 64'(wb_addr), 64'd0);
    rst = 1'b0;
    step();

    // fill from word 0
    clr();
    send(1'b0, 32'h0000_1000, '0);
    wait_done(1, "t1");
    check("t1_dcyc", 64'(done_cyc - base), 64'd26);
    check("t1_err", 64'(done_err), 64'd0);
    check("t1_nrd", 64'(rq_idx.size()), 64'(LW));
    check_fill(0, 0, "t1");
    check_addrs(32'h0000_1000, 0, "t1");
    check("t1_we", 64'(log_we[0]), 64'h0);
    check("t1_din", 64'(log_din[3]), 64'h0);

    // fill critical word 7 first
    clr();
    send(1'b0, 32'h0000_101C, '0);
    wait_done(1, "t2");
    check("t2_dcyc", 64'(done_cyc - base), 64'd26);
    check("t2_nrd", 64'(rq_idx.size()), 64'(LW));
    check_fill(7, 0, "t2");
    check_addrs(32'h0000_1000, 7, "t2");

    // writeback
    clr();
    for (int i = 0; i < LW; i++) wd[32*i +: 32] = 32'h1111_1111 * i;
    send(1'b1, 32'h0000_2000, wd);
    check("t3_we_c1", 64'(wb_we), 64'hF);
    wait_done(1, "t3");
    check("t3_dcyc", 64'(done_cyc - base), 64'd26);
    check("t3_err", 64'(done_err), 64'd0);
    check("t3_nrd", 64'(rq_idx.size()), 64'd0);
    check_addrs(32'h0000_2000, 0, "t3");
    for (int k = 0; k < LW; k++) begin
      if (k < log_din.size()) begin
        check("t3_we", 64'(log_we[k]), 64'hF);
        check("t3_din", 64'(log_din[k]), 64'(32'h1111_1111 * k));
      end
    end

    // slave never answers
    clr();
    mute = 1'b1;
    send(1'b0, 32'h0000_3000, '0);
    while (cyc < base + TO) step();
    check("t4_stb_last", 64'(wb_stb), 64'd1);
    check("t4_nodone", 64'(done), 64'd0);
    step();
    check("t4_done", 64'(done), 64'd1);
    check("t4_err", 64'(err), 64'd1);
    check("t4_stb_off", 64'(wb_stb), 64'd0);
    check("t4_ready", 64'(req_ready), 64'd1);
    step();
    check("t4_pulse", 64'(done), 64'd0);
    check("t4_nrd", 64'(rq_idx.size()), 64'd0);
    mute = 1'b0;

    // reset in the middle of a fill
    clr();
    send(1'b0, 32'h0000_1000, '0);
    while (cyc < base + 10) step();
    check("t5_stb_pre", 64'(wb_stb), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_stb_rst", 64'(wb_stb), 64'd0);
    check("t5_rdy_rst", 64'(req_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    check("t5_nodone", 64'(done_cnt), 64'd0);
    clr();
    send(1'b0, 32'h0000_1000, '0);
    wait_done(1, "t5");
    check("t5_dcyc", 64'(done_cyc - base), 64'd26);
    check("t5_nrd", 64'(rq_idx.size()), 64'(LW));
    check_fill(0, 0, "t5");

    // request held high across done: back-to-back lines
    clr();
    step();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_1004;
    base      = cyc;
    step();
    check("t6_stb_c1", 64'(wb_stb), 64'd1);
    wait_done(1, "t6a");
    check("t6_dcyc1", 64'(done_cyc - base), 64'd26);
    check("t6_rdy", 64'(req_ready), 64'd1);
    step();
    check("t6_stb2", 64'(wb_stb), 64'd1);
    check("t6_rdy2", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    wait_done(2, "t6b");
    check("t6_dcyc2", 64'(done_cyc - base), 64'd52);
    check("t6_nrd", 64'(rq_idx.size()), 64'(2 * LW));
    check_fill(1, 0, "t6a");
    check_fill(1, LW, "t6b");

    check("err_alone", 64'(err_lone), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_line_master.md
Name: sram_line_master

Overview:
- Wishbone-side bus initiator that drives the SRAM controller's stb/nak port.
- Moves one cache line of LINE_WORDS 32-bit words per request, either as a line fill (read) or a writeback (write).
- Uses critical-word-first wrap ordering.
- Pipelines issue so the next word is presented while the previous one completes; sits between the cache/refill logic and the SRAM controller.

Parameters:
LINE_WORDS, 8, words per line; power of two, 2..16
TIMEOUT, 64, max cycles waiting for any single accept or completion before abort; 2..255

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  line request
req_ready  out  1  high in IDLE only; request accepted on valid&ready
req_write  in  1  1 = writeback, 0 = fill
req_addr  in  32  byte address; bits [log2(LINE_WORDS)+1:2] select the first word
req_wdata  in  LINE_WORDS*32  writeback data, word i at [32i+31:32i]; sampled on accept
rd_valid  out  1  one-cycle pulse per completed read word
rd_idx  out  log2(LINE_WORDS)  word index within line for rd_data
rd_data  out  32  captured wb_dout[31:0]
done  out  1  one-cycle pulse, transfer finished
err  out  1  one-cycle pulse coincident with done on timeout abort
wb_stb  out  1  request strobe
wb_addr  out  32  word-aligned byte address, bits [1:0]=0
wb_we  out  4  4'b1111 for write, 4'b0000 for read
wb_din  out  32  write data
wb_dout  in  48  read data; only [31:0] used
wb_nak  in  1  slave busy flag

Behaviour:
- Reset (async): all outputs 0 except req_ready=1. State IDLE, counters 0, nak_q=0.
- Slave protocol, fixed:
  - Slave samples stb/addr/we/din only when idle or in its result cycle.
  - It raises nak the cycle after sampling and holds nak high 2 cycles.
  - nak low again = result cycle; read data is valid on wb_dout in that cycle.
- accept = wb_nak & ~nak_q; complete = ~wb_nak & nak_q (nak_q = wb_nak registered).
- Word order: start index s = req_addr word offset; k-th word index = (s+k) mod LINE_WORDS.
  - Address = {req_addr[31:log2(LINE_WORDS)+2], index, 2'b00}; wraps within the line and never crosses it.
- States:
  - IDLE: req_ready=1. On accept of a request, latch write flag, address and wdata, and set issue count and completion count to 0. Next cycle: BUSY with wb_stb=1, addr/we/din of word 0.
  - BUSY, on accept: if issue count < LINE_WORDS-1, wb_addr/wb_din advance to the next word the following cycle with wb_stb held high. Else wb_stb goes to 0 the following cycle.
  - BUSY, on complete: for a read, the following cycle pulses rd_valid with rd_idx of the completed word and rd_data = wb_dout[31:0] sampled in the complete cycle. Completion count increments.
    - If the completion count reaches LINE_WORDS: go to IDLE; done=1 that cycle (same cycle as the final rd_valid), and req_ready=1 from that cycle.
  - accept and complete never coincide; complete without a preceding accept (nak_q=0) is ignored.
- Throughput: 3 cycles/word. For LINE_WORDS=8, request accepted at cycle 0:
  - stb at cycle 1, first accept at cycle 2, first complete at cycle 4, last complete at cycle 25.
  - done at cycle 26.
- Timeout: a counter resets on every accept or complete and counts in BUSY otherwise.
  - If it reaches TIMEOUT: wb_stb=0 next cycle, done=1 and err=1 that cycle, no further rd_valid, return to IDLE.
- wb_we and wb_din stay constant for the whole transfer except for the word advance. wb_din=0 for reads.
- req_valid while busy is ignored, with req_ready=0.
- Reset mid-transfer: wb_stb drops immediately (async); no done or err pulse.

Test Plan:
- Fill, req_addr=0x00001000, slave model gives data=0xA0+addr[4:2] -> rd_idx 0..7 in order, rd_data 0xA0..0xA7, done at cycle 26, err=0.
- Fill, req_addr=0x0000101C -> wb_addr sequence 0x101C,0x1000,0x1004..0x1018; rd_idx 7,0,1..6.
- Writeback, req_addr=0x2000, word i = 0x11111111*i -> wb_we=4'hF, wb_din matches at each accept, no rd_valid, done after 8 completes.
- Slave never raises nak -> wb_stb drops and done=err=1 at cycle TIMEOUT+1 after stb; req_ready=1 afterwards.
- rst asserted at cycle 10 of a fill -> wb_stb=0 and req_ready=1 immediately. A new fill after release completes all 8 words with correct data.
- req_valid held high through done -> second transfer starts only after req_ready=1, back-to-back with no lost words.
